// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS core pipeline slice.
// Holds datapath/address/alucontrol widths, the alucontrol encodings,
// the decoded control bundle layout and a small register-match helper
// used by both the capture bypass and the EX forwarding muxes.
package mips_pkg;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int ACW = 3;

  typedef enum logic [ACW-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Field order of the decoded control bundle, MSB first.
  typedef struct packed {
    logic           regwrite;
    logic           memtoreg;
    logic           memwrite;
    logic           alusrc;
    logic           regdst;
    logic [ACW-1:0] alucontrol;
  } ctrl_t;

  // A write port "hits" a source register only when it is enabled,
  // addresses that register, and the register is not $0.
  function automatic logic regMatch(input logic          we,
                                    input logic [AW-1:0] wa,
                                    input logic [AW-1:0] src);
    return we && (wa == src) && (src != '0);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bus between the ID-side/MEM/WB environment and the
// ID/EX pipeline register.
// master: drives ID inputs, flush, MEM and WB feedback; reads stall and ex_*.
// slave : the id_ex_stage block itself.
interface id_ex_stage_if;
  import mips_pkg::*;

  logic           flush;
  logic           id_valid;
  logic [AW-1:0]  id_rs;
  logic [AW-1:0]  id_rt;
  logic [AW-1:0]  id_rd;
  logic [DW-1:0]  id_rd1;
  logic [DW-1:0]  id_rd2;
  logic [DW-1:0]  id_imm;
  logic           id_regwrite;
  logic           id_memtoreg;
  logic           id_memwrite;
  logic           id_alusrc;
  logic           id_regdst;
  logic [ACW-1:0] id_alucontrol;

  logic           mem_regwrite;
  logic [AW-1:0]  mem_wa;
  logic [DW-1:0]  mem_aluout;
  logic           wb_regwrite;
  logic [AW-1:0]  wb_wa;
  logic [DW-1:0]  wb_result;

  logic           stall;
  logic           ex_valid;
  logic           ex_regwrite;
  logic           ex_memtoreg;
  logic           ex_memwrite;
  logic           ex_alusrc;
  logic           ex_regdst;
  logic [ACW-1:0] ex_alucontrol;
  logic [AW-1:0]  ex_wa;
  logic [DW-1:0]  ex_srca;
  logic [DW-1:0]  ex_writedata;
  logic [DW-1:0]  ex_imm;

  modport master (
    output flush, id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm,
           id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst,
           id_alucontrol, mem_regwrite, mem_wa, mem_aluout,
           wb_regwrite, wb_wa, wb_result,
    input  stall, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite,
           ex_alusrc, ex_regdst, ex_alucontrol, ex_wa, ex_srca,
           ex_writedata, ex_imm
  );

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_rd, id_rd1, id_rd2, id_imm,
           id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst,
           id_alucontrol, mem_regwrite, mem_wa, mem_aluout,
           wb_regwrite, wb_wa, wb_result,
    output stall, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite,
           ex_alusrc, ex_regdst, ex_alucontrol, ex_wa, ex_srca,
           ex_writedata, ex_imm
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: EX-stage operand forwarding select.
// Ports:
//   src_i                       registered source register of the operand
//   mem_regwrite_i/wa_i/data_i  EX/MEM write-back candidate
//   wb_regwrite_i/wa_i/data_i   MEM/WB write-back candidate
//   captured_i                  operand captured at the ID/EX edge
//   operand_o                   forwarded operand
// MEM is the younger result, so it wins over WB when both match.
module fwd_mux
  import mips_pkg::*;
(
  input  logic [AW-1:0] src_i,
  input  logic          mem_regwrite_i,
  input  logic [AW-1:0] mem_wa_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_regwrite_i,
  input  logic [AW-1:0] wb_wa_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [DW-1:0] captured_i,
  output logic [DW-1:0] operand_o
);

  always_comb begin
    operand_o = captured_i;
    if (regMatch(mem_regwrite_i, mem_wa_i, src_i)) begin
      operand_o = mem_data_i;
    end else if (regMatch(wb_regwrite_i, wb_wa_i, src_i)) begin
      operand_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high; clears every register
//   bus    id_ex_stage_if.slave: ID inputs, flush, MEM/WB feedback in;
//          stall, ex_valid, ex_* controls, ex_wa, forwarded ex_srca /
//          ex_writedata and ex_imm out
// Captures regfile operands with a same-edge WB bypass, detects load-use
// hazards (stall + bubble) and forwards MEM/WB results into EX.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  id_ex_stage_if.slave bus
);

  logic          valid_q, valid_d;
  ctrl_t         ctrl_q,  ctrl_d;
  logic [AW-1:0] wa_q,    wa_d;
  logic [AW-1:0] rs_q,    rs_d;
  logic [AW-1:0] rt_q,    rt_d;
  logic [DW-1:0] opA_q,   opA_d;
  logic [DW-1:0] opB_q,   opB_d;
  logic [DW-1:0] imm_q,   imm_d;

  logic [DW-1:0] capA;
  logic [DW-1:0] capB;
  logic          stall;
  ctrl_t         idCtrl;

  assign idCtrl = '{regwrite:   bus.id_regwrite,
                    memtoreg:   bus.id_memtoreg,
                    memwrite:   bus.id_memwrite,
                    alusrc:     bus.id_alusrc,
                    regdst:     bus.id_regdst,
                    alucontrol: bus.id_alucontrol};

  // The regfile writes on the same edge that this stage captures, so the
  // value read in ID is stale when WB targets the same register.
  always_comb begin
    capA = regMatch(bus.wb_regwrite, bus.wb_wa, bus.id_rs) ? bus.wb_result : bus.id_rd1;
    capB = regMatch(bus.wb_regwrite, bus.wb_wa, bus.id_rt) ? bus.wb_result : bus.id_rd2;
  end

  // Load-use: the load in EX has no data until MEM, so ID must wait a cycle.
  always_comb begin
    stall = valid_q && ctrl_q.memtoreg && ctrl_q.regwrite && (wa_q != '0) &&
            ((wa_q == bus.id_rs) || (wa_q == bus.id_rt)) && bus.id_valid;
  end

  // Flush and stall both insert a fully zeroed bubble; otherwise load ID.
  always_comb begin
    valid_d = bus.id_valid;
    ctrl_d  = idCtrl;
    wa_d    = bus.id_regdst ? bus.id_rd : bus.id_rt;
    rs_d    = bus.id_rs;
    rt_d    = bus.id_rt;
    opA_d   = capA;
    opB_d   = capB;
    imm_d   = bus.id_imm;
    if (bus.flush || stall) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      wa_d    = '0;
      rs_d    = '0;
      rt_d    = '0;
      opA_d   = '0;
      opB_d   = '0;
      imm_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      wa_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      wa_q    <= wa_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      imm_q   <= imm_d;
    end
  end

  fwd_mux u_fwdA (
    .src_i          (rs_q),
    .mem_regwrite_i (bus.mem_regwrite),
    .mem_wa_i       (bus.mem_wa),
    .mem_data_i     (bus.mem_aluout),
    .wb_regwrite_i  (bus.wb_regwrite),
    .wb_wa_i        (bus.wb_wa),
    .wb_data_i      (bus.wb_result),
    .captured_i     (opA_q),
    .operand_o      (bus.ex_srca)
  );

  fwd_mux u_fwdB (
    .src_i          (rt_q),
    .mem_regwrite_i (bus.mem_regwrite),
    .mem_wa_i       (bus.mem_wa),
    .mem_data_i     (bus.mem_aluout),
    .wb_regwrite_i  (bus.wb_regwrite),
    .wb_wa_i        (bus.wb_wa),
    .wb_data_i      (bus.wb_result),
    .captured_i     (opB_q),
    .operand_o      (bus.ex_writedata)
  );

  assign bus.stall         = stall;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_regwrite   = ctrl_q.regwrite;
  assign bus.ex_memtoreg   = ctrl_q.memtoreg;
  assign bus.ex_memwrite   = ctrl_q.memwrite;
  assign bus.ex_alusrc     = ctrl_q.alusrc;
  assign bus.ex_regdst     = ctrl_q.regdst;
  assign bus.ex_alucontrol = ctrl_q.alucontrol;
  assign bus.ex_wa         = wa_q;
  assign bus.ex_imm        = imm_q;

endmodule
